// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// reset values and a byte-lane merge helper.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [3:0] OFF_CYCLE   = 4'h0;
  localparam logic [3:0] OFF_SCRATCH = 4'h4;
  localparam logic [3:0] OFF_IRQ_CMP = 4'h8;
  localparam logic [3:0] OFF_STATUS  = 4'hC;

  localparam logic [31:0] IRQ_CMP_RESET = 32'hFFFF_FFFF;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-enabled synchronous single-port RAM. Read data is registered and only
// changes on an enabled read, so it stays stable while a response is stalled.
// Contents are deliberately left uninitialised.
module dmem_ram #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [0:(1<<AW)-1];
  logic [31:0] rdata_q;

  // Per-lane write on enabled write; capture the word on enabled read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (we[i]) begin
            mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: decodes each request to RAM, MMIO or error and
// returns a single registered response one cycle after acceptance.
// Optional MMIO window (CYCLE/SCRATCH/IRQ_CMP/STATUS) is built only when the
// macro DMEM_RESPONDER_MMIO_EN is defined; otherwise that window decodes as error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  logic        accept_s;
  logic        hit_ram_s;
  logic        hit_mmio_s;
  logic        is_write_s;
  logic [31:0] mmio_rdata_s;
  logic [31:0] ram_rdata_s;
  logic        unused_addr_s;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_sel_ram_q, rsp_sel_ram_d;

  assign req_ready     = !rsp_valid_q || rsp_ready;
  assign accept_s      = req_valid && req_ready;
  assign is_write_s    = (req_we != 4'b0000);
  assign hit_ram_s     = (req_addr[31:DEPTH_LOG2+2] == '0);
  assign unused_addr_s = ^req_addr[1:0];

  dmem_ram #(.AW(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .en    (accept_s && hit_ram_s),
    .we    (req_we),
    .addr  (req_addr[DEPTH_LOG2+1:2]),
    .wdata (req_wdata),
    .rdata (ram_rdata_s)
  );

`ifdef DMEM_RESPONDER_MMIO_EN
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] irq_cmp_q, irq_cmp_d;
  logic [3:0]  mmio_off_s;

  assign hit_mmio_s = (req_addr[31:4] == MMIO_BASE[31:4]);
  assign mmio_off_s = {req_addr[3:2], 2'b00};

  // MMIO read mux; values are those held before the acceptance edge.
  always_comb begin
    mmio_rdata_s = 32'd0;
    case (mmio_off_s)
      OFF_CYCLE:   mmio_rdata_s = cycle_q;
      OFF_SCRATCH: mmio_rdata_s = scratch_q;
      OFF_IRQ_CMP: mmio_rdata_s = irq_cmp_q;
      OFF_STATUS:  mmio_rdata_s = {31'd0, (cycle_q >= irq_cmp_q)};
      default:     mmio_rdata_s = 32'd0;
    endcase
  end

  // MMIO next state: free-running counter, byte-enabled register writes.
  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    scratch_d = scratch_q;
    irq_cmp_d = irq_cmp_q;
    if (accept_s && hit_mmio_s && is_write_s) begin
      case (mmio_off_s)
        OFF_SCRATCH: scratch_d = merge_bytes(scratch_q, req_wdata, req_we);
        OFF_IRQ_CMP: irq_cmp_d = merge_bytes(irq_cmp_q, req_wdata, req_we);
        default:     scratch_d = scratch_q;
      endcase
    end else begin
      scratch_d = scratch_q;
    end
  end

  // MMIO register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= 32'd0;
      scratch_q <= 32'd0;
      irq_cmp_q <= IRQ_CMP_RESET;
    end else begin
      cycle_q   <= cycle_d;
      scratch_q <= scratch_d;
      irq_cmp_q <= irq_cmp_d;
    end
  end
`else
  assign hit_mmio_s   = 1'b0;
  assign mmio_rdata_s = 32'd0;
`endif

  // Response next state: load on accept, clear on release, otherwise hold.
  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_err_d     = rsp_err_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_sel_ram_d = rsp_sel_ram_q;
    if (accept_s) begin
      rsp_valid_d   = 1'b1;
      rsp_err_d     = !(hit_ram_s || hit_mmio_s);
      rsp_sel_ram_d = hit_ram_s && !is_write_s;
      if (hit_mmio_s && !is_write_s) begin
        rsp_rdata_d = mmio_rdata_s;
      end else begin
        rsp_rdata_d = 32'd0;
      end
    end else if (rsp_ready) begin
      rsp_valid_d   = 1'b0;
      rsp_err_d     = 1'b0;
      rsp_rdata_d   = 32'd0;
      rsp_sel_ram_d = 1'b0;
    end else begin
      rsp_valid_d   = rsp_valid_q;
    end
  end

  // Response register; reset discards any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_sel_ram_q <= 1'b0;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_sel_ram_q <= rsp_sel_ram_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_sel_ram_q ? ram_rdata_s : rsp_rdata_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 10, meaning the RAM holds 2^DEPTH_LOG2 32-bit words.
REQ-002 The block SHALL have parameter MMIO_BASE, default 32'h8000_0000, meaning the base address of the MMIO window.
REQ-003 clk  input  1  clock; one clock, all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted when high together with req_valid.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_we  input  4  byte write enables; 4'b0000 means read.
REQ-009 req_wdata  input  32  write data, already lane-aligned.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  access decoded to no target.

Function
REQ-014 Handshake: a request SHALL be accepted only on a cycle where req_valid && req_ready.
REQ-015 req_ready SHALL equal !rsp_valid || rsp_ready, so there is a single outstanding response and no bubble at full rate.
REQ-016 Latency: the response to a request accepted in cycle N SHALL be valid in cycle N+1.
REQ-017 rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready is sampled high.
REQ-018 Decode, RAM: a request SHALL target the RAM when req_addr[31:2] < 2^DEPTH_LOG2; the word index is req_addr[DEPTH_LOG2+1:2].
REQ-019 Decode, MMIO: a request SHALL target MMIO when req_addr[31:4] == MMIO_BASE[31:4] and MMIO is compiled in.
REQ-020 Decode, error: any other address SHALL return rsp_err=1 and rsp_rdata=0, with no state change.
REQ-021 RAM write: each byte lane i SHALL be written only where req_we[i]=1; other lanes are unchanged.
REQ-022 A write SHALL return rsp_valid with rsp_rdata=0 and rsp_err=0.
REQ-023 RAM read: rsp_rdata SHALL be the full 32-bit word at the index; lane selection and sign extension are the requester's job.
REQ-024 Read-after-write: a read accepted in the cycle after a write to the same word SHALL return the newly written bytes.
REQ-025 MMIO offset 0x0, CYCLE: a 32-bit counter that increments by 1 every cycle, wraps 0xFFFF_FFFF->0, and is read-only (writes are ignored).
REQ-026 MMIO offset 0x4, SCRATCH: 32-bit read/write register with byte enables.
REQ-027 MMIO offset 0x8, IRQ_CMP: 32-bit read/write register.
REQ-028 MMIO offset 0xC, STATUS: read-only; bit0 = (CYCLE >= IRQ_CMP), unsigned; other bits 0.
REQ-029 The CYCLE value returned SHALL be the value sampled at the acceptance edge.
REQ-030 A request accepted while rsp_ready=1 releases the old response and loads the new one in the same edge; the old response SHALL not be dropped or duplicated.
REQ-031 The RAM SHALL not be initialised; a read of a never-written word returns X in simulation.

Reset
REQ-032 While rst_n=0: rsp_valid=0, rsp_err=0, rsp_rdata=0, CYCLE=0, SCRATCH=0, IRQ_CMP=32'hFFFF_FFFF; req_ready reads 1.
REQ-033 When reset asserts mid-transaction, the pending response SHALL be discarded; RAM contents are not reset.
REQ-034 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-035 Macro DMEM_RESPONDER_MMIO_EN defined: the MMIO window and its registers SHALL exist as specified.
REQ-036 Macro DMEM_RESPONDER_MMIO_EN undefined: no MMIO registers SHALL be synthesised, and MMIO-window addresses SHALL decode as errors.

Structure
REQ-037 A shared package dmem_pkg SHALL hold the MMIO offsets (CYCLE, SCRATCH, IRQ_CMP, STATUS), the IRQ_CMP reset value and the default MMIO_BASE.
REQ-038 A sub-module dmem_ram SHALL implement the byte-enabled synchronous single-port RAM.
REQ-039 Decode, the response register and MMIO SHALL live in the top module.

Verification
REQ-040 Write then read: write 0xDEADBEEF to 0x10 with we=4'b1111, then write we=4'b0010 data 0x0000_5500, then read 0x10 -> rsp_rdata=0xDEAD55EF, one cycle after acceptance.
REQ-041 Backpressure: hold rsp_ready=0 for 3 cycles after a read -> req_ready=0 and the response stays stable; raise rsp_ready together with a new request -> the two responses arrive in order with no gap.
REQ-042 Error: read address 0x4000_0000 (DEPTH_LOG2=10) -> rsp_err=1, rsp_rdata=0, RAM unchanged.
REQ-043 MMIO (macro on): write IRQ_CMP=20, read STATUS before and after cycle 20 -> bit0 goes 0 then 1; write to CYCLE is ignored.
REQ-044 MMIO (macro off): read MMIO_BASE+0x4 -> rsp_err=1.
REQ-045 Reset: assert rst_n low while rsp_valid=1 -> rsp_valid=0 immediately; after release, SCRATCH=0 and IRQ_CMP=0xFFFF_FFFF.
